hazard_scoreboard: RTL and testbench

- Pipeline hazard controller for the 5-stage CPU. It consumes the per-instruction register-use and writer fields that ID hands to the ID/EX register.
- Keeps its own shadow scoreboard of in-flight writers in EX, MEM and WB, with Tnew ageing each cycle. From this it drives the stall, ID/EX bubble and forwarding selects for the ID-stage and EX-stage operands.
- Also tracks a multi-cycle mult/div busy window and stalls HI/LO users behind it.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/md_busy_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding selects, Tuse/Tnew encodings and
// the scoreboard entry type used by the hazard controller.
package cpu_pkg;

   localparam logic [1:0] FWD_GRF = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_PC8  = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic       we;
      logic [4:0] wa;
      logic [1:0] tnew;
   } sb_entry_t;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // $0 is hard-wired, so a writer targeting it never produces a usable value.
   function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
      return e.we && (e.wa == r) && (r != 5'd0);
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy window of the multiply/divide unit: loaded when an MD op leaves EX,
// then counts down to zero.
module md_busy_counter #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic div,
   output logic busy
);

   logic [3:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 4'd0;
      end else if (start) begin
         count <= div ? 4'(DIV_CYC) : 4'(MULT_CYC);
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign busy = (count != 4'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/bubble/forwarding controller for the 5-stage CPU, driven by a shadow
// scoreboard of the writers currently in EX, MEM and WB.
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RA1_ID,
   input  logic [4:0] RA2_ID,
   input  logic [1:0] Tuse1_ID,
   input  logic [1:0] Tuse2_ID,
   input  logic [4:0] WA_ID,
   input  logic       GRFWE_ID,
   input  logic [1:0] Tnew_ID,
   input  logic       md_start_ID,
   input  logic       md_div_ID,
   input  logic       md_use_ID,
   output logic       stall,
   output logic       idex_flush,
   output logic [1:0] fwd_rs_ID,
   output logic [1:0] fwd_rt_ID,
   output logic [1:0] fwd_a_EX,
   output logic [1:0] fwd_b_EX,
   output logic       md_busy
);

   sb_entry_t  ex_e, mem_e, wb_e;
   logic [4:0] ex_ra1, ex_ra2;
   logic       ex_md_start, ex_md_div;
   logic       data_stall, md_stall;

   // First matching stage wins; it is a source only once its value exists.
   // WB tnew is always 0 by construction, so its check never blocks a match.
   function automatic logic [1:0] pick(input sb_entry_t e, input logic [4:0] r,
                                       input logic [1:0] sel, input logic [1:0] rest);
      if (sb_match(e, r)) return (e.tnew == 2'd0) ? sel : FWD_GRF;
      return rest;
   endfunction

   function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input sb_entry_t ex, input sb_entry_t mem);
      if (tuse == TUSE_NONE) return 1'b0;
      return (sb_match(ex, r) && ex.tnew > tuse) || (sb_match(mem, r) && mem.tnew > tuse);
   endfunction

   always_comb begin
      data_stall = src_stall(RA1_ID, Tuse1_ID, ex_e, mem_e) |
                   src_stall(RA2_ID, Tuse2_ID, ex_e, mem_e);
      md_stall   = md_use_ID && (md_busy || ex_md_start);
      stall      = data_stall | md_stall;
      idex_flush = stall;
      fwd_rs_ID  = pick(ex_e, RA1_ID, FWD_EX, pick(mem_e, RA1_ID, FWD_MEM, pick(wb_e, RA1_ID, FWD_WB, FWD_GRF)));
      fwd_rt_ID  = pick(ex_e, RA2_ID, FWD_EX, pick(mem_e, RA2_ID, FWD_MEM, pick(wb_e, RA2_ID, FWD_WB, FWD_GRF)));
      fwd_a_EX   = pick(mem_e, ex_ra1, FWD_MEM, pick(wb_e, ex_ra1, FWD_WB, FWD_GRF));
      fwd_b_EX   = pick(mem_e, ex_ra2, FWD_MEM, pick(wb_e, ex_ra2, FWD_WB, FWD_GRF));
   end

   // ID -> EX -> MEM -> WB scoreboard advance; a stall injects a bubble into EX.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_e        <= '0;
         mem_e       <= '0;
         wb_e        <= '0;
         ex_ra1      <= 5'd0;
         ex_ra2      <= 5'd0;
         ex_md_start <= 1'b0;
         ex_md_div   <= 1'b0;
      end else begin
         wb_e  <= '{we: mem_e.we, wa: mem_e.wa, tnew: tnew_dec(mem_e.tnew)};
         mem_e <= '{we: ex_e.we, wa: ex_e.wa, tnew: tnew_dec(ex_e.tnew)};
         if (stall) begin
            ex_e        <= '0;
            ex_ra1      <= 5'd0;
            ex_ra2      <= 5'd0;
            ex_md_start <= 1'b0;
            ex_md_div   <= 1'b0;
         end else begin
            ex_e        <= '{we: GRFWE_ID, wa: WA_ID, tnew: Tnew_ID};
            ex_ra1      <= RA1_ID;
            ex_ra2      <= RA2_ID;
            ex_md_start <= md_start_ID;
            ex_md_div   <= md_div_ID;
         end
      end
   end

   md_busy_counter #(
      .MULT_CYC(MULT_CYC),
      .DIV_CYC (DIV_CYC)
   ) u_md_busy_counter (
      .clk  (clk),
      .reset(reset),
      .start(ex_md_start),
      .div  (ex_md_div),
      .busy (md_busy)
   );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, ALU and PC8
// forwarding, $0 writers, MD busy windows and reset during a divide.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RA1_ID, RA2_ID, WA_ID;
   logic [1:0] Tuse1_ID, Tuse2_ID, Tnew_ID;
   logic       GRFWE_ID, md_start_ID, md_div_ID, md_use_ID;
   logic       stall, idex_flush, md_busy;
   logic [1:0] fwd_rs_ID, fwd_rt_ID, fwd_a_EX, fwd_b_EX;

   int n_checks = 0;
   int n_fails  = 0;

   hazard_scoreboard #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .RA1_ID     (RA1_ID),
      .RA2_ID     (RA2_ID),
      .Tuse1_ID   (Tuse1_ID),
      .Tuse2_ID   (Tuse2_ID),
      .WA_ID      (WA_ID),
      .GRFWE_ID   (GRFWE_ID),
      .Tnew_ID    (Tnew_ID),
      .md_start_ID(md_start_ID),
      .md_div_ID  (md_div_ID),
      .md_use_ID  (md_use_ID),
      .stall      (stall),
      .idex_flush (idex_flush),
      .fwd_rs_ID  (fwd_rs_ID),
      .fwd_rt_ID  (fwd_rt_ID),
      .fwd_a_EX   (fwd_a_EX),
      .fwd_b_EX   (fwd_b_EX),
      .md_busy    (md_busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [1:0] tu1, input logic [1:0] tu2,
                         input logic [4:0] wa, input logic we, input logic [1:0] tn,
                         input logic mds, input logic mdd, input logic mdu);
      RA1_ID = ra1; RA2_ID = ra2; Tuse1_ID = tu1; Tuse2_ID = tu2;
      WA_ID = wa; GRFWE_ID = we; Tnew_ID = tn;
      md_start_ID = mds; md_div_ID = mdd; md_use_ID = mdu;
   endtask

   task automatic set_nop;
      set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain;
      set_nop();
      repeat (4) tick();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      set_nop();
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall got %0d want 0", stall); end
      n_checks++; if (idex_flush !== 1'b0) begin n_fails++; $display("FAIL reset_flush got %0d want 0", idex_flush); end
      n_checks++; if (fwd_rs_ID !== 2'd0) begin n_fails++; $display("FAIL reset_fwd_rs got %0d want 0", fwd_rs_ID); end
      n_checks++; if (fwd_rt_ID !== 2'd0) begin n_fails++; $display("FAIL reset_fwd_rt got %0d want 0", fwd_rt_ID); end
      n_checks++; if (fwd_a_EX !== 2'd0) begin n_fails++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a_EX); end
      n_checks++; if (fwd_b_EX !== 2'd0) begin n_fails++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b_EX); end
      n_checks++; if (md_busy !== 1'b0) begin n_fails++; $display("FAIL reset_md_busy got %0d want 0", md_busy); end
   endtask

   // lw $1,0($0) ; addu $2,$1,$3
   task automatic test_load_use;
      drain();
      set_id(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL lu_lw_issue got %0d want 0", stall); end
      tick();
      set_id(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL lu_stall got %0d want 1", stall); end
      n_checks++; if (idex_flush !== 1'b1) begin n_fails++; $display("FAIL lu_flush got %0d want 1", idex_flush); end
      tick();
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL lu_release got %0d want 0", stall); end
      tick();
      set_nop();
      #1;
      n_checks++; if (fwd_a_EX !== 2'd3) begin n_fails++; $display("FAIL lu_fwd_a got %0d want 3", fwd_a_EX); end
      n_checks++; if (fwd_b_EX !== 2'd0) begin n_fails++; $display("FAIL lu_fwd_b got %0d want 0", fwd_b_EX); end
   endtask

   // lw $1,0($0) ; beq $1,$0
   task automatic test_load_branch;
      drain();
      set_id(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL lb_stall1 got %0d want 1", stall); end
      tick();
      n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL lb_stall2 got %0d want 1", stall); end
      tick();
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL lb_release got %0d want 0", stall); end
      n_checks++; if (fwd_rs_ID !== 2'd3) begin n_fails++; $display("FAIL lb_fwd_rs got %0d want 3", fwd_rs_ID); end
      n_checks++; if (fwd_rt_ID !== 2'd0) begin n_fails++; $display("FAIL lb_fwd_rt got %0d want 0", fwd_rt_ID); end
   endtask

   // addu $4,$0,$0 ; addu $5,$4,$4
   task automatic test_alu_fwd;
      drain();
      set_id(5'd0, 5'd0, 2'd1, 2'd1, 5'd4, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(5'd4, 5'd4, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL alu_stall got %0d want 0", stall); end
      n_checks++; if (fwd_rs_ID !== 2'd0) begin n_fails++; $display("FAIL alu_fwd_rs_pending got %0d want 0", fwd_rs_ID); end
      tick();
      set_nop();
      #1;
      n_checks++; if (fwd_a_EX !== 2'd2) begin n_fails++; $display("FAIL alu_fwd_a got %0d want 2", fwd_a_EX); end
      n_checks++; if (fwd_b_EX !== 2'd2) begin n_fails++; $display("FAIL alu_fwd_b got %0d want 2", fwd_b_EX); end
   endtask

   // jal ; jr $31 ; then lw $0 followed by beq $0,$0
   task automatic test_jal_zero;
      drain();
      set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL jr_stall got %0d want 0", stall); end
      n_checks++; if (fwd_rs_ID !== 2'd1) begin n_fails++; $display("FAIL jr_fwd_rs got %0d want 1", fwd_rs_ID); end
      tick();
      set_id(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL zero_stall got %0d want 0", stall); end
      n_checks++; if (fwd_rs_ID !== 2'd0) begin n_fails++; $display("FAIL zero_fwd_rs got %0d want 0", fwd_rs_ID); end
      n_checks++; if (fwd_rt_ID !== 2'd0) begin n_fails++; $display("FAIL zero_fwd_rt got %0d want 0", fwd_rt_ID); end
   endtask

   // div $8,$9 ; mflo $10 ; then mult $8,$9
   task automatic test_md;
      int n_stall;
      int n_busy;
      drain();
      set_id(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL div_issue got %0d want 0", stall); end
      tick();
      set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      n_stall = 0;
      n_busy  = 0;
      for (int i = 0; i < 14; i++) begin
         #1;
         if (stall) n_stall++;
         if (md_busy) begin
            n_busy++;
            n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL mflo_busy_stall got %0d want 1", stall); end
         end
         tick();
      end
      n_checks++; if (n_busy !== 10) begin n_fails++; $display("FAIL div_busy_cycles got %0d want 10", n_busy); end
      n_checks++; if (n_stall !== 11) begin n_fails++; $display("FAIL mflo_stall_cycles got %0d want 11", n_stall); end
      set_id(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL mult_issue got %0d want 0", stall); end
      tick();
      set_nop();
      n_busy = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (md_busy) n_busy++;
         tick();
      end
      n_checks++; if (n_busy !== 5) begin n_fails++; $display("FAIL mult_busy_cycles got %0d want 5", n_busy); end
   endtask

   task automatic test_reset_mid_div;
      drain();
      set_id(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
      tick();
      set_nop();
      tick();
      tick();
      n_checks++; if (md_busy !== 1'b1) begin n_fails++; $display("FAIL mid_div_busy got %0d want 1", md_busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      #1;
      n_checks++; if (md_busy !== 1'b0) begin n_fails++; $display("FAIL rst_div_busy got %0d want 0", md_busy); end
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL rst_div_stall got %0d want 0", stall); end
      n_checks++; if ({fwd_rs_ID, fwd_rt_ID, fwd_a_EX, fwd_b_EX} !== 8'd0) begin
         n_fails++; $display("FAIL rst_div_fwd got %0h want 0", {fwd_rs_ID, fwd_rt_ID, fwd_a_EX, fwd_b_EX});
      end
   endtask

   initial begin
      reset = 1'b1;
      set_nop();
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_fwd();
      test_jal_zero();
      test_md();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
